// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared constants and types for the register-file write-port arbiter
package wb_port_arbiter_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    typedef enum logic {EMPTY, FULL} out_state_e;
endpackage

// File: rtl/mux2way32b.sv
// mux2way32b: 2-way 32-bit data select
module mux2way32b (
    input  logic [31:0] in0_i,
    input  logic [31:0] in1_i,
    input  logic        sel_i,
    output logic [31:0] out_o
);
    assign out_o = sel_i ? in1_i : in0_i;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin sharing of the register-file write port between ALU and load results
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  conflict_cnt
);
    import wb_port_arbiter_pkg::*;

    out_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              both, out_free, accept, load;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign both       = req0_valid & req1_valid;
    assign grant      = both ? (ptr_q ? 2'b10 : 2'b01) : {req1_valid, req0_valid};
    assign out_free   = (state_q == EMPTY) | wr_ready;
    assign req0_ready = grant[REQ_ALU] & out_free;
    assign req1_ready = grant[REQ_MEM] & out_free;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign sel_addr   = grant[REQ_MEM] ? req1_addr : req0_addr;
    assign load       = accept & (sel_addr != ADDR_W'(REG_ZERO));

    mux2way32b u_mux (
        .in0_i (req0_data),
        .in1_i (req1_data),
        .sel_i (grant[REQ_MEM]),
        .out_o (sel_data)
    );

    // Output-stage next state, pointer handoff to the loser, saturating contention count
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = FULL;
            addr_d  = sel_addr;
            data_d  = sel_data;
        end else if (state_q == FULL && wr_ready) begin
            state_d = EMPTY;
        end
        if (accept && both) ptr_d = grant[REQ_ALU];
        if (both && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers; reset drops any pending write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_en        = (state_q == FULL);
    assign wr_addr      = addr_q;
    assign wr_data      = data_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector-table check of the write-port arbiter
module tb_wb_port_arbiter;
    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_addr, req1_addr, wr_addr;
    logic [31:0] req0_data, req1_data, wr_data;
    logic        wr_en, wr_ready;
    logic [1:0]  grant;
    logic [15:0] conflict_cnt;
    int          n_assert = 0;
    int          n_fail = 0;

    localparam logic [31:0] DA = 32'hAAAA_AAAA;
    localparam logic [31:0] DB = 32'hBBBB_BBBB;
    localparam logic [31:0] DC = 32'hCCCC_CCCC;
    localparam logic [31:0] DE = 32'hDEAD_BEEF;
    localparam logic [31:0] DL = 32'h1111_2222;
    localparam logic [31:0] D0 = 32'h0000_1234;
    localparam logic [31:0] DX = 32'h0A0A_0A0A;
    localparam logic [31:0] DY = 32'h0B0B_0B0B;

    typedef struct packed {
        logic        r0v;
        logic [4:0]  r0a;
        logic [31:0] r0d;
        logic        r1v;
        logic [4:0]  r1a;
        logic [31:0] r1d;
        logic        wrr;
        logic [1:0]  g;
        logic        e0;
        logic        e1;
        logic        en;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl [18];

    wb_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .grant        (grant),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1, input logic wrr);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        wr_ready = wrr;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd3,  DE,    1'b0, 5'd0,  32'd0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd3,  DE, 16'd0};
        tbl[1]  = '{1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd3,  DE, 16'd0};
        tbl[2]  = '{1'b1, 5'd1,  DA,    1'b1, 5'd2,  DB,    1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1,  DA, 16'd1};
        tbl[3]  = '{1'b1, 5'd1,  DA,    1'b1, 5'd2,  DB,    1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd2,  DB, 16'd2};
        tbl[4]  = '{1'b1, 5'd1,  DA,    1'b1, 5'd2,  DB,    1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1,  DA, 16'd3};
        tbl[5]  = '{1'b1, 5'd1,  DA,    1'b1, 5'd2,  DB,    1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd2,  DB, 16'd4};
        tbl[6]  = '{1'b1, 5'd7,  DC,    1'b0, 5'd0,  32'd0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd7,  DC, 16'd4};
        tbl[7]  = '{1'b0, 5'd0,  32'd0, 1'b1, 5'd9,  DL,    1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd7,  DC, 16'd4};
        tbl[8]  = '{1'b0, 5'd0,  32'd0, 1'b1, 5'd9,  DL,    1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd7,  DC, 16'd4};
        tbl[9]  = '{1'b0, 5'd0,  32'd0, 1'b1, 5'd9,  DL,    1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd7,  DC, 16'd4};
        tbl[10] = '{1'b0, 5'd0,  32'd0, 1'b1, 5'd9,  DL,    1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd9,  DL, 16'd4};
        tbl[11] = '{1'b0, 5'd0,  32'd0, 1'b1, 5'd0,  D0,    1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 5'd9,  DL, 16'd4};
        tbl[12] = '{1'b0, 5'd0,  32'd0, 1'b1, 5'd0,  D0,    1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 5'd9,  DL, 16'd4};
        tbl[13] = '{1'b1, 5'd0,  32'd5, 1'b1, 5'd4,  32'd6, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 5'd9,  DL, 16'd5};
        tbl[14] = '{1'b1, 5'd0,  32'd5, 1'b1, 5'd4,  32'd6, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd4,  32'd6, 16'd6};
        tbl[15] = '{1'b1, 5'd10, DX,    1'b1, 5'd11, DY,    1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 5'd4,  32'd6, 16'd7};
        tbl[16] = '{1'b1, 5'd10, DX,    1'b1, 5'd11, DY,    1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd10, DX, 16'd8};
        tbl[17] = '{1'b0, 5'd0,  32'd0, 1'b0, 5'd0,  32'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd10, DX, 16'd8};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, 1'($urandom));
        end
        @(posedge clk); #1;
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        chk("reset wr_data", wr_data, 32'd0);
        chk("reset conflict_cnt", 32'(conflict_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd1, DA, 1'b1, 5'd2, DB, 1'b1);
        #1;
        chk("post-reset grant", 32'(grant), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].r0v, tbl[i].r0a, tbl[i].r0d, tbl[i].r1v, tbl[i].r1a, tbl[i].r1d, tbl[i].wrr);
            #1;
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].e0));
            chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].e1));
            @(posedge clk); #1;
            chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(tbl[i].en));
            chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(tbl[i].ea));
            chk($sformatf("v%0d wr_data", i), wr_data, tbl[i].ed);
            chk($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(tbl[i].ec));
        end

        @(negedge clk);
        drive(1'b1, 5'd10, DX, 1'b1, 5'd11, DY, 1'b1);
        repeat (65541) @(posedge clk);
        #1;
        chk("saturated conflict_cnt", 32'(conflict_cnt), 32'h0000_FFFF);
        @(negedge clk);
        wr_ready = 1'b0;
        @(posedge clk); #1;
        chk("stall wr_en", 32'(wr_en), 32'd1);
        chk("no wrap conflict_cnt", 32'(conflict_cnt), 32'h0000_FFFF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset wr_en", 32'(wr_en), 32'd0);
        chk("async reset wr_data", wr_data, 32'd0);
        chk("async reset conflict_cnt", 32'(conflict_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_ready = 1'b1;
        #1;
        chk("re-reset grant", 32'(grant), 32'd1);
        chk("re-reset req0_ready", 32'(req0_ready), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        chk("discarded entry wr_en", 32'(wr_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
